// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered 32-bit ALU: datapath width, the
// opcode type and the opcode encodings used by alu_core and alu_shifter.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0000;
  localparam alu_op_t ALU_SUB = 4'b0001;
  localparam alu_op_t ALU_AND = 4'b0010;
  localparam alu_op_t ALU_OR  = 4'b0011;
  localparam alu_op_t ALU_NOT = 4'b0100;
  localparam alu_op_t ALU_SRA = 4'b1000;
  localparam alu_op_t ALU_SLL = 4'b1001;
  localparam alu_op_t ALU_SRL = 4'b1010;
  localparam alu_op_t ALU_ROL = 4'b1100;
  localparam alu_op_t ALU_ROR = 4'b1101;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational single-bit shift/rotate unit for the ALU.
// Ports:
//   i_a   [31:0] operand to shift (operand B is never used here)
//   i_op  [3:0]  opcode; only SRA/SLL/SRL/ROL/ROR produce a non-zero result
//   o_res [31:0] shifted/rotated value, 0 for any other opcode
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  alu_op_t          i_op,
  output logic [ALU_W-1:0] o_res
);

  // Select the shift/rotate by one position
  always_comb begin
    o_res = {ALU_W{1'b0}};
    case (i_op)
      ALU_SRA: o_res = {i_a[ALU_W-1], i_a[ALU_W-1:1]};
      ALU_SLL: o_res = {i_a[ALU_W-2:0], 1'b0};
      ALU_SRL: o_res = {1'b0, i_a[ALU_W-1:1]};
      ALU_ROL: o_res = {i_a[ALU_W-2:0], i_a[ALU_W-1]};
      ALU_ROR: o_res = {i_a[0], i_a[ALU_W-1:1]};
      default: o_res = {ALU_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Registered 32-bit integer ALU (execute stage). Result and flags are captured
// one clock after the operands when En=1, and hold when En=0.
// Configuration macro: ALU_FLAGS_EN adds the Cout and Ovf ports/registers.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (Out=0, Zero=1, flags=0)
//   En         capture enable
//   A, B [31:0] operands
//   Op   [3:0]  operation select (see alu_pkg)
//   Out  [31:0] registered result
//   Zero        registered, 1 when the captured result is zero
//   Cout        registered carry / no-borrow   (ALU_FLAGS_EN only)
//   Ovf         registered signed overflow     (ALU_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [3:0]       Op,
`ifdef ALU_FLAGS_EN
  output logic             Cout,
  output logic             Ovf,
`endif
  output logic [ALU_W-1:0] Out,
  output logic             Zero
);

  logic [ALU_W-1:0] w_add;
  logic [ALU_W-1:0] w_sub;
  logic [ALU_W-1:0] w_shift;
  logic [ALU_W-1:0] w_res;
  logic             w_zero;

  logic [ALU_W-1:0] r_out;
  logic             r_zero;

  alu_shifter u_shifter (
    .i_a   (A),
    .i_op  (Op),
    .o_res (w_shift)
  );

`ifdef ALU_FLAGS_EN
  // Widen by one bit so bit 32 carries the adder carry-out; for subtraction
  // bit 32 is the borrow, so "no borrow" is its inverse.
  logic [ALU_W:0] w_add_ext;
  logic [ALU_W:0] w_sub_ext;
  logic           w_cout;
  logic           w_ovf;
  logic           r_cout;
  logic           r_ovf;

  assign w_add_ext = {1'b0, A} + {1'b0, B};
  assign w_sub_ext = {1'b0, A} - {1'b0, B};
  assign w_add     = w_add_ext[ALU_W-1:0];
  assign w_sub     = w_sub_ext[ALU_W-1:0];

  // Carry and signed-overflow flags; only ADD and SUB produce non-zero flags
  always_comb begin
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (Op)
      ALU_ADD: begin
        w_cout = w_add_ext[ALU_W];
        w_ovf  = (A[ALU_W-1] == B[ALU_W-1]) && (w_add[ALU_W-1] != A[ALU_W-1]);
      end
      ALU_SUB: begin
        w_cout = ~w_sub_ext[ALU_W];
        w_ovf  = (A[ALU_W-1] != B[ALU_W-1]) && (w_sub[ALU_W-1] != A[ALU_W-1]);
      end
      default: begin
        w_cout = 1'b0;
        w_ovf  = 1'b0;
      end
    endcase
  end

  // Flag registers, cleared by reset and held while En=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (En) begin
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign Cout = r_cout;
  assign Ovf  = r_ovf;
`else
  assign w_add = A + B;
  assign w_sub = A - B;
`endif

  // Result multiplexer; unused opcodes yield zero
  always_comb begin
    w_res = {ALU_W{1'b0}};
    case (Op)
      ALU_ADD: w_res = w_add;
      ALU_SUB: w_res = w_sub;
      ALU_AND: w_res = A & B;
      ALU_OR:  w_res = A | B;
      ALU_NOT: w_res = ~A;
      ALU_SRA, ALU_SLL, ALU_SRL, ALU_ROL, ALU_ROR: w_res = w_shift;
      default: w_res = {ALU_W{1'b0}};
    endcase
  end

  // Zero reflects the value being captured, not the current Out
  assign w_zero = (w_res == {ALU_W{1'b0}});

  // Result registers; reset value is Out=0 with Zero=1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= {ALU_W{1'b0}};
      r_zero <= 1'b1;
    end else if (En) begin
      r_out  <= w_res;
      r_zero <= w_zero;
    end
  end

  assign Out  = r_out;
  assign Zero = r_zero;

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Self-checking bench for alu_core: directed vectors, randomized operations
// against a behavioural model, and a reset/enable sequence.
// -----------------------------------------------------------------------------
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic        En;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic [31:0] Out;
  logic        Zero;
`ifdef ALU_FLAGS_EN
  logic        Cout;
  logic        Ovf;
`endif

  int n_checks;
  int n_errors;

  // Expected register contents
  logic [31:0] exp_out;
  logic        exp_zero;
  logic        exp_cout;
  logic        exp_ovf;

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .En    (En),
    .A     (A),
    .B     (B),
    .Op    (Op),
`ifdef ALU_FLAGS_EN
    .Cout  (Cout),
    .Ovf   (Ovf),
`endif
    .Out   (Out),
    .Zero  (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural result model written from the operation table
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~a;
      4'd8:    return sa >>> 1;
      4'd9:    return a << 1;
      4'd10:   return a >> 1;
      4'd12:   return (a << 1) | (a >> 31);
      4'd13:   return (a >> 1) | (a << 31);
      default: return 32'h0;
    endcase
  endfunction

  // Flags from full-precision arithmetic: {cout, ovf}
  function automatic logic [1:0] model_flags(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (op == 4'd0) begin
      s = sa + sb;
      return {(ua + ub) > 64'sd4294967295, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
    end else if (op == 4'd1) begin
      s = sa - sb;
      return {ua >= ub, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
    end else begin
      return 2'b00;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".out"}, Out, exp_out);
    check_val({tag, ".zero"}, {31'd0, Zero}, {31'd0, exp_zero});
`ifdef ALU_FLAGS_EN
    check_val({tag, ".cout"}, {31'd0, Cout}, {31'd0, exp_cout});
    check_val({tag, ".ovf"}, {31'd0, Ovf}, {31'd0, exp_ovf});
`endif
  endtask

  // Drive one cycle of stimulus at the falling edge, update the model,
  // then check one delta after the next rising edge
  task automatic do_cycle(input string tag, input logic en, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    logic [1:0] f;
    @(negedge clk);
    En = en; Op = op; A = a; B = b;
    @(posedge clk);
    if (en) begin
      exp_out  = model_res(op, a, b);
      exp_zero = (exp_out == 32'h0);
      f        = model_flags(op, a, b);
      exp_cout = f[1];
      exp_ovf  = f[0];
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    exp_out  = 32'h0;
    exp_zero = 1'b1;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1; En = 1'b0; A = 32'h0; B = 32'h0; Op = 4'h0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ADD with latency check: Out unchanged before the edge
    @(negedge clk);
    En = 1'b1; Op = 4'd0; A = 32'd1; B = 32'd2;
    #1 check_val("add_latency", Out, 32'h0);
    do_cycle("add_1_2", 1'b1, 4'd0, 32'd1, 32'd2);
    check_val("add_1_2_val", Out, 32'd3);
    do_cycle("add_11_20", 1'b1, 4'd0, 32'd11, 32'd20);
    check_val("add_11_20_val", Out, 32'd31);

    do_cycle("sub_3_m1", 1'b1, 4'd1, 32'd3, 32'hFFFF_FFFF);
    check_val("sub_3_m1_val", Out, 32'd4);
    do_cycle("sub_eq", 1'b1, 4'd1, 32'h1234, 32'h1234);
    check_val("sub_eq_zero", {31'd0, Zero}, 32'd1);
    do_cycle("and", 1'b1, 4'd2, 32'h0000_000F, 32'h0000_000A);
    check_val("and_val", Out, 32'h0000_000A);
    do_cycle("or", 1'b1, 4'd3, 32'h0000_000F, 32'h0000_000A);
    check_val("or_val", Out, 32'h0000_000F);
    do_cycle("not", 1'b1, 4'd4, 32'h0, 32'h1234_5678);
    check_val("not_val", Out, 32'hFFFF_FFFF);
    do_cycle("sra", 1'b1, 4'd8, 32'h8000_0001, 32'hDEAD_BEEF);
    check_val("sra_val", Out, 32'hC000_0000);
    do_cycle("srl", 1'b1, 4'd10, 32'h8000_0001, 32'hDEAD_BEEF);
    check_val("srl_val", Out, 32'h4000_0000);
    do_cycle("sll", 1'b1, 4'd9, 32'h8000_0001, 32'hDEAD_BEEF);
    check_val("sll_val", Out, 32'h0000_0002);
    do_cycle("rol", 1'b1, 4'd12, 32'h8000_0001, 32'hDEAD_BEEF);
    check_val("rol_val", Out, 32'h0000_0003);
    do_cycle("ror", 1'b1, 4'd13, 32'h8000_0001, 32'hDEAD_BEEF);
    check_val("ror_val", Out, 32'hC000_0000);
    do_cycle("add_ovf", 1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1);
    check_val("add_ovf_val", Out, 32'h8000_0000);
    do_cycle("add_carry", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1);
    check_val("add_carry_zero", {31'd0, Zero}, 32'd1);

    // Randomized operations, including holds and forced equal operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      logic        ren;
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rop = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 3) != 0);
      do_cycle("rand", ren, rop, ra, rb);
    end

    // Reset while a result is pending
    do_cycle("pre_reset", 1'b1, 4'd0, 32'd5, 32'd5);
    @(negedge clk);
    En = 1'b1; Op = 4'd0; A = 32'd7; B = 32'd9;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_reset");
    @(posedge clk); #1 check_outputs("reset_hold");

    // Release with En=0: stay at reset values
    @(negedge clk);
    rst_n = 1'b1; En = 1'b0;
    do_cycle("release_en0", 1'b0, 4'd0, 32'd7, 32'd9);
    do_cycle("release_en0b", 1'b0, 4'd1, 32'd1, 32'd9);

    // Unused opcode gives zero
    do_cycle("nonzero", 1'b1, 4'd3, 32'h10, 32'h1);
    do_cycle("unused_op", 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("unused_op_zero", {31'd0, Zero}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
